// File: rtl/retire_lockstep_checker.sv
// Lockstep retire checker: queues golden writeback retires and compares DUT retires in order.
// Optional RETIRE_CMP_MASK_EN adds a per-entry wdata compare mask (gold_rt_mask).
module retire_lockstep_checker #(
  parameter int NUM_RET = 1,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic [NUM_RET-1:0]    gold_rt_valid,
  input  logic [32*NUM_RET-1:0] gold_rt_pc,
  input  logic [5*NUM_RET-1:0]  gold_rt_waddr,
  input  logic [32*NUM_RET-1:0] gold_rt_wdata,
`ifdef RETIRE_CMP_MASK_EN
  input  logic [32*NUM_RET-1:0] gold_rt_mask,
`endif
  input  logic [NUM_RET-1:0]    dut_rt_valid,
  input  logic [32*NUM_RET-1:0] dut_rt_pc,
  input  logic [5*NUM_RET-1:0]  dut_rt_waddr,
  input  logic [32*NUM_RET-1:0] dut_rt_wdata,
  input  logic                  dut_mem_wen,
  input  logic [31:0]           dut_mem_addr,
  input  logic [31:0]           dut_mem_wdata,
  input  logic                  uart_fifo_empty,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            err_code,
  output logic [31:0]           err_pc,
  output logic [31:0]           err_exp,
  output logic [31:0]           err_got,
  output logic [31:0]           retire_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int SW = PW + 2;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_PASS, ST_FAIL} state_t;

  logic [31:0] mem_pc    [DEPTH];
  logic [4:0]  mem_waddr [DEPTH];
  logic [31:0] mem_wdata [DEPTH];
`ifdef RETIRE_CMP_MASK_EN
  logic [31:0] mem_mask  [DEPTH];
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          done_q, done_d, pass_q, pass_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [31:0]   err_pc_q, err_pc_d, err_exp_q, err_exp_d, err_got_q, err_got_d;
  logic [31:0]   retire_cnt_q, retire_cnt_d;

  logic [NUM_RET-1:0]    g_act, d_act;
  logic [SW-1:0]         push_off [NUM_RET];
  logic [SW-1:0]         pop_off  [NUM_RET];
  logic [SW-1:0]         n_push, n_pop, avail, occ_next;
  logic [3*NUM_RET-1:0]  lane_err;
  logic [NUM_RET-1:0]    lane_match;
  logic [32*NUM_RET-1:0] lane_pc, lane_exp, lane_got;
  logic [2:0]            sel_code;
  logic [31:0]           sel_pc, sel_exp, sel_got, n_match;
  logic                  running, any_err, finish, tmr_clr;

  for (genvar gi = 0; gi < NUM_RET; gi++) begin : g_act_lane
    assign g_act[gi] = gold_rt_valid[gi] && (gold_rt_waddr[5*gi +: 5] != 5'd0);
    assign d_act[gi] = dut_rt_valid[gi] && (dut_rt_waddr[5*gi +: 5] != 5'd0);
  end

  // Slot of each active lane within this cycle's push/pop group, in lane order.
  always_comb begin
    n_push = '0;
    n_pop  = '0;
    for (int l = 0; l < NUM_RET; l++) begin
      push_off[l] = n_push;
      pop_off[l]  = n_pop;
      n_push      = n_push + SW'(g_act[l]);
      n_pop       = n_pop + SW'(d_act[l]);
    end
    avail = SW'(occ_q) + n_push;
  end

  for (genvar gi = 0; gi < NUM_RET; gi++) begin : g_cmp_lane
    logic [31:0]   e_pc, e_wdata, e_mask, d_pc, d_wdata, m_exp, m_got, x_exp, x_got;
    logic [4:0]    e_waddr, d_waddr;
    logic [SW-1:0] byp_idx;
    logic [PW-1:0] rd_idx;
    logic [2:0]    code;

    assign d_pc    = dut_rt_pc[32*gi +: 32];
    assign d_waddr = dut_rt_waddr[5*gi +: 5];
    assign d_wdata = dut_rt_wdata[32*gi +: 32];
    assign byp_idx = pop_off[gi] - SW'(occ_q);
    assign rd_idx  = rd_ptr_q + pop_off[gi][PW-1:0];

    // Virtual queue: stored entries first, then this cycle's golden lanes.
    always_comb begin
      e_pc    = '0;
      e_waddr = '0;
      e_wdata = '0;
      e_mask  = '1;
      if (pop_off[gi] < SW'(occ_q)) begin
        e_pc    = mem_pc[rd_idx];
        e_waddr = mem_waddr[rd_idx];
        e_wdata = mem_wdata[rd_idx];
`ifdef RETIRE_CMP_MASK_EN
        e_mask  = mem_mask[rd_idx];
`endif
      end else begin
        for (int g = 0; g < NUM_RET; g++) begin
          if (g_act[g] && (push_off[g] == byp_idx)) begin
            e_pc    = gold_rt_pc[32*g +: 32];
            e_waddr = gold_rt_waddr[5*g +: 5];
            e_wdata = gold_rt_wdata[32*g +: 32];
`ifdef RETIRE_CMP_MASK_EN
            e_mask  = gold_rt_mask[32*g +: 32];
`endif
          end
        end
      end
    end

    assign m_exp = e_wdata & e_mask;
    assign m_got = d_wdata & e_mask;

    always_comb begin
      code  = 3'd0;
      x_exp = '0;
      x_got = '0;
      if (d_act[gi]) begin
        if (pop_off[gi] >= avail) begin
          code  = 3'd4;
          x_got = d_wdata;
        end else if (d_pc != e_pc) begin
          code  = 3'd1;
          x_exp = e_pc;
          x_got = d_pc;
        end else if (d_waddr != e_waddr) begin
          code  = 3'd2;
          x_exp = {27'd0, e_waddr};
          x_got = {27'd0, d_waddr};
        end else if (m_got != m_exp) begin
          code  = 3'd3;
          x_exp = m_exp;
          x_got = m_got;
        end
      end
    end

    assign lane_err[3*gi +: 3]  = code;
    assign lane_match[gi]       = d_act[gi] && (code == 3'd0);
    assign lane_pc[32*gi +: 32] = d_pc;
    assign lane_exp[32*gi +: 32] = x_exp;
    assign lane_got[32*gi +: 32] = x_got;
  end

  // Lowest erroring lane wins; queue-level errors only when no lane failed.
  always_comb begin
    sel_code = 3'd0;
    sel_pc   = '0;
    sel_exp  = '0;
    sel_got  = '0;
    n_match  = '0;
    for (int l = 0; l < NUM_RET; l++) begin
      n_match = n_match + 32'(lane_match[l]);
      if ((sel_code == 3'd0) && (lane_err[3*l +: 3] != 3'd0)) begin
        sel_code = lane_err[3*l +: 3];
        sel_pc   = lane_pc[32*l +: 32];
        sel_exp  = lane_exp[32*l +: 32];
        sel_got  = lane_got[32*l +: 32];
      end
    end
    occ_next = avail - n_pop;
    tmr_clr  = (n_pop != '0) || (occ_q == '0);
    if (sel_code == 3'd0) begin
      if (occ_next > SW'(DEPTH)) begin
        sel_code = 3'd5;
      end else if (!tmr_clr && (tmr_q == TW'(TIMEOUT - 1))) begin
        sel_code = 3'd6;
      end
    end
  end

  assign running = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign any_err = running && (sel_code != 3'd0);
  assign finish  = dut_mem_wen && (dut_mem_addr == 32'h0000_000C) && (dut_mem_wdata == 32'd0);

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    occ_d        = occ_q;
    tmr_d        = tmr_q;
    retire_cnt_d = retire_cnt_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_code_d   = err_code_q;
    err_pc_d     = err_pc_q;
    err_exp_d    = err_exp_q;
    err_got_d    = err_got_q;
    if (running) begin
      rd_ptr_d     = rd_ptr_q + n_pop[PW-1:0];
      wr_ptr_d     = wr_ptr_q + n_push[PW-1:0];
      occ_d        = occ_next[OW-1:0];
      tmr_d        = tmr_clr ? '0 : tmr_q + TW'(1);
      retire_cnt_d = retire_cnt_q + n_match;
      if (any_err) begin
        state_d    = ST_FAIL;
        done_d     = 1'b1;
        err_code_d = sel_code;
        err_pc_d   = sel_pc;
        err_exp_d  = sel_exp;
        err_got_d  = sel_got;
      end else if ((state_q == ST_RUN) && finish) begin
        state_d = ST_DRAIN;
      end else if ((state_q == ST_DRAIN) && (occ_q == '0) && uart_fifo_empty) begin
        state_d = ST_PASS;
        done_d  = 1'b1;
        pass_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q      <= ST_RUN;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      tmr_q        <= '0;
      retire_cnt_q <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_code_q   <= '0;
      err_pc_q     <= '0;
      err_exp_q    <= '0;
      err_got_q    <= '0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      tmr_q        <= tmr_d;
      retire_cnt_q <= retire_cnt_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_code_q   <= err_code_d;
      err_pc_q     <= err_pc_d;
      err_exp_q    <= err_exp_d;
      err_got_q    <= err_got_d;
    end
  end

  // Storage needs no reset: the pointers and occupancy define what is valid.
  always_ff @(posedge sys_clk) begin
    if (running) begin
      for (int l = 0; l < NUM_RET; l++) begin
        if (g_act[l]) begin
          mem_pc[wr_ptr_q + push_off[l][PW-1:0]]    <= gold_rt_pc[32*l +: 32];
          mem_waddr[wr_ptr_q + push_off[l][PW-1:0]] <= gold_rt_waddr[5*l +: 5];
          mem_wdata[wr_ptr_q + push_off[l][PW-1:0]] <= gold_rt_wdata[32*l +: 32];
`ifdef RETIRE_CMP_MASK_EN
          mem_mask[wr_ptr_q + push_off[l][PW-1:0]]  <= gold_rt_mask[32*l +: 32];
`endif
        end
      end
    end
  end

  assign done       = done_q;
  assign pass       = pass_q;
  assign err_code   = err_code_q;
  assign err_pc     = err_pc_q;
  assign err_exp    = err_exp_q;
  assign err_got    = err_got_q;
  assign retire_cnt = retire_cnt_q;

endmodule
